// File: rtl/layer_cfg_bank.sv
// Multi-channel NeoPixel bit-timing register bank. Host writes go to shadow registers.
// Each channel copies shadow to active only at an idle edge while a commit is pending.
module layer_cfg_bank #(
  parameter int unsigned CH_NUM    = 8,
  parameter int unsigned CH_AW     = 3,
  parameter int unsigned RST_BYTES = 2,
  parameter logic [7:0]  T0H_DEF   = 8'h00,
  parameter logic [7:0]  T0L_DEF   = 8'h00,
  parameter logic [7:0]  T1H_DEF   = 8'h00,
  parameter logic [7:0]  T1L_DEF   = 8'h00,
  parameter logic [8*RST_BYTES-1:0] RST_DEF = '0
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          wr_en_in,
  input  logic [CH_AW+2:0]              wr_addr_in,
  input  logic [7:0]                    wr_data_in,
  input  logic                          rd_en_in,
  input  logic [CH_AW+3:0]              rd_addr_in,
  output logic [7:0]                    rd_data_out,
  output logic                          rd_valid_out,
  input  logic [CH_NUM-1:0]             ch_idle_in,
  output logic [8*CH_NUM-1:0]           t0h_cnt_out,
  output logic [8*CH_NUM-1:0]           t0l_cnt_out,
  output logic [8*CH_NUM-1:0]           t1h_cnt_out,
  output logic [8*CH_NUM-1:0]           t1l_cnt_out,
  output logic [8*RST_BYTES*CH_NUM-1:0] rst_cnt_out,
  output logic [CH_NUM-1:0]             cfg_pend_out,
  output logic [CH_NUM-1:0]             cfg_upd_out
);

  localparam int unsigned RST_W = 8 * RST_BYTES;

  typedef struct packed {
    logic [7:0]       t0h;
    logic [7:0]       t0l;
    logic [7:0]       t1h;
    logic [7:0]       t1l;
    logic [RST_W-1:0] rst;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{t0h: T0H_DEF, t0l: T0L_DEF, t1h: T1H_DEF,
                               t1l: T1L_DEF, rst: RST_DEF};

  cfg_t              shadow_q [CH_NUM];
  cfg_t              shadow_d [CH_NUM];
  cfg_t              active_q [CH_NUM];
  cfg_t              active_d [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] upd_q, upd_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q;

  logic [CH_AW-1:0]  wr_ch, rd_ch;
  logic [2:0]        wr_reg, rd_reg;
  logic              rd_bank;

  assign wr_ch   = wr_addr_in[CH_AW+2:3];
  assign wr_reg  = wr_addr_in[2:0];
  assign rd_bank = rd_addr_in[CH_AW+3];
  assign rd_ch   = rd_addr_in[CH_AW+2:3];
  assign rd_reg  = rd_addr_in[2:0];

  // Byte view of one register set; reset-count bytes are MSB first from reg 4.
  function automatic logic [7:0] cfg_byte(input cfg_t c, input logic [2:0] r);
    logic [7:0] b;
    b = '0;
    case (r)
      3'd0:    b = c.t0h;
      3'd1:    b = c.t0l;
      3'd2:    b = c.t1h;
      3'd3:    b = c.t1l;
      default: begin
        for (int i = 0; i < int'(RST_BYTES); i++)
          if (r == 3'(4 + i)) b = c.rst[RST_W-8-8*i +: 8];
      end
    endcase
    return b;
  endfunction

  // Transfer uses the pre-write shadow; the write and commit decode runs after it
  // so a same-edge commit re-arms pend for a second transfer.
  always_comb begin
    // NOTE: every comb output gets a full default first, otherwise untouched paths infer latches.
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    upd_d    = '0;

    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (pend_q[c] && ch_idle_in[c]) begin
        active_d[c] = shadow_q[c];
        pend_d[c]   = 1'b0;
        upd_d[c]    = 1'b1;
      end

      // Channels that do not exist never match, so out-of-range writes vanish.
      if (wr_en_in && wr_ch == CH_AW'(c)) begin
        case (wr_reg)
          3'd0:    shadow_d[c].t0h = wr_data_in;
          3'd1:    shadow_d[c].t0l = wr_data_in;
          3'd2:    shadow_d[c].t1h = wr_data_in;
          3'd3:    shadow_d[c].t1l = wr_data_in;
          3'd7:    if (wr_data_in[0]) pend_d[c] = 1'b1;
          default: begin
            for (int i = 0; i < int'(RST_BYTES); i++)
              if (wr_reg == 3'(4 + i)) shadow_d[c].rst[RST_W-8-8*i +: 8] = wr_data_in;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (rd_ch == CH_AW'(c)) begin
        if (rd_reg == 3'd7) rd_data_d = {7'b0, pend_q[c]};
        else                rd_data_d = cfg_byte(rd_bank ? active_q[c] : shadow_q[c], rd_reg);
      end
    end
  end

  // NOTE: the register arrays are reset because the drivers need the default timing from the first frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < int'(CH_NUM); c++) begin
        shadow_q[c] <= CFG_DEF;
        active_q[c] <= CFG_DEF;
      end
      pend_q     <= '0;
      upd_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge state of the others.
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      upd_q      <= upd_d;
      rd_valid_q <= rd_en_in;
      if (rd_en_in) rd_data_q <= rd_data_d;
    end
  end

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_out
    assign t0h_cnt_out[8*g +: 8]         = active_q[g].t0h;
    assign t0l_cnt_out[8*g +: 8]         = active_q[g].t0l;
    assign t1h_cnt_out[8*g +: 8]         = active_q[g].t1h;
    assign t1l_cnt_out[8*g +: 8]         = active_q[g].t1l;
    assign rst_cnt_out[RST_W*g +: RST_W] = active_q[g].rst;
  end

  assign cfg_pend_out = pend_q;
  assign cfg_upd_out  = upd_q;
  assign rd_data_out  = rd_data_q;
  assign rd_valid_out = rd_valid_q;

endmodule

// File: tb/tb_layer_cfg_bank.sv
// Self-checking bench for layer_cfg_bank: directed scenarios plus random traffic,
// checked against a byte-array model of the shadow/active banks.
module tb_layer_cfg_bank;

  localparam int NCH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic [7:0]   ch_idle;
  logic [63:0]  t0h, t0l, t1h, t1l;
  logic [127:0] rst_cnt;
  logic [7:0]   pend, upd;

  int n_vec = 0;
  int n_err = 0;

  layer_cfg_bank #(
    .CH_NUM(8), .CH_AW(4), .RST_BYTES(2),
    .T0H_DEF(8'h10), .T0L_DEF(8'h20), .T1H_DEF(8'h30), .T1L_DEF(8'h40),
    .RST_DEF(16'h1F40)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr),
    .rd_data_out(rd_data), .rd_valid_out(rd_valid),
    .ch_idle_in(ch_idle),
    .t0h_cnt_out(t0h), .t0l_cnt_out(t0l), .t1h_cnt_out(t1h), .t1l_cnt_out(t1l),
    .rst_cnt_out(rst_cnt), .cfg_pend_out(pend), .cfg_upd_out(upd)
  );

  always #5 clk = ~clk;

  // Model: per channel a byte array indexed by register number (6,7 unused).
  logic [7:0] m_sh [NCH][8];
  logic [7:0] m_ac [NCH][8];
  logic [7:0] m_pend, m_upd, m_rd_data;
  logic       m_rd_valid;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h1F, 8'h40, 8'h00, 8'h00};
      m_ac[c] = m_sh[c];
    end
    m_pend = '0; m_upd = '0; m_rd_data = '0; m_rd_valid = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] ra);
    int ch = int'(ra[6:3]);
    int r  = int'(ra[2:0]);
    if (ch >= NCH) return 8'h00;
    if (r == 7)    return {7'b0, m_pend[ch]};
    if (r > 5)     return 8'h00;
    return ra[7] ? m_ac[ch][r] : m_sh[ch][r];
  endfunction

  function automatic logic [63:0] exp_field(input int f);
    logic [63:0] v;
    for (int c = 0; c < NCH; c++) v[8*c +: 8] = m_ac[c][f];
    return v;
  endfunction

  function automatic logic [127:0] exp_rst();
    logic [127:0] v;
    for (int c = 0; c < NCH; c++) v[16*c +: 16] = {m_ac[c][4], m_ac[c][5]};
    return v;
  endfunction

  // One clock: drive inputs, take the edge, advance the model from pre-edge state.
  task automatic step(input logic we, input logic [6:0] wa, input logic [7:0] wd,
                      input logic re, input logic [7:0] ra, input logic [7:0] idle);
    int ch, r;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; ch_idle = idle;
    @(posedge clk);
    m_rd_valid = re;
    if (re) m_rd_data = model_read(ra);
    for (int c = 0; c < NCH; c++) begin
      m_upd[c] = m_pend[c] & idle[c];
      if (m_upd[c]) begin
        m_ac[c]   = m_sh[c];
        m_pend[c] = 1'b0;
      end
    end
    ch = int'(wa[6:3]);
    r  = int'(wa[2:0]);
    if (we && ch < NCH) begin
      if (r <= 5)               m_sh[ch][r] = wd;
      else if (r == 7 && wd[0]) m_pend[ch] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_step(input logic [7:0] idle);
    step(1'b0, 7'h00, 8'h00, 1'b0, 8'h00, idle);
  endtask

  task automatic test_reset();
    n_vec++; if (t0h !== 64'h1010101010101010) begin n_err++; $display("FAIL reset_t0h: got %h expected %h", t0h, 64'h1010101010101010); end
    n_vec++; if ({t0l, t1h, t1l} !== {exp_field(1), exp_field(2), exp_field(3)}) begin n_err++; $display("FAIL reset_timing: got %h expected %h", {t0l, t1h, t1l}, {exp_field(1), exp_field(2), exp_field(3)}); end
    n_vec++; if (rst_cnt !== {8{16'h1F40}}) begin n_err++; $display("FAIL reset_rst: got %h expected %h", rst_cnt, {8{16'h1F40}}); end
    n_vec++; if (pend !== 8'h00 || upd !== 8'h00) begin n_err++; $display("FAIL reset_pend_upd: got %h/%h expected 00/00", pend, upd); end
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd: got %b/%h expected 0/00", rd_valid, rd_data); end
  endtask

  task automatic test_shadow_write();
    logic [7:0] vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'hCD};
    for (int r = 0; r < 6; r++) step(1'b1, {4'd2, 3'(r)}, vals[r], 1'b0, 8'h00, 8'h00);
    n_vec++; if (t0h !== exp_field(0) || rst_cnt !== exp_rst()) begin n_err++; $display("FAIL shadow_active_held: got %h/%h expected %h/%h", t0h, rst_cnt, exp_field(0), exp_rst()); end
    step(1'b0, 7'h00, 8'h00, 1'b1, {1'b0, 4'd2, 3'd5}, 8'h00);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hCD) begin n_err++; $display("FAIL shadow_read: got %b/%h expected 1/cd", rd_valid, rd_data); end
    step(1'b0, 7'h00, 8'h00, 1'b1, {1'b1, 4'd2, 3'd5}, 8'h00);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h40) begin n_err++; $display("FAIL active_read_old: got %b/%h expected 1/40", rd_valid, rd_data); end
    idle_step(8'h00);
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
  endtask

  task automatic test_commit_wait();
    int bad = 0;
    step(1'b1, {4'd2, 3'd7}, 8'h01, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      idle_step(8'hFB);
      if (pend[2] !== 1'b1 || upd !== 8'h00 || t0h !== exp_field(0)) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL commit_wait: got %0d bad cycles expected 0", bad); end
    idle_step(8'h04);
    n_vec++; if (rst_cnt[47:32] !== 16'hABCD || t0h[23:16] !== 8'h11) begin n_err++; $display("FAIL commit_xfer: got %h/%h expected abcd/11", rst_cnt[47:32], t0h[23:16]); end
    n_vec++; if (upd !== 8'h04 || pend !== 8'h00) begin n_err++; $display("FAIL commit_upd: got %h/%h expected 04/00", upd, pend); end
    n_vec++; if ({t0h, t0l, t1h, t1l, rst_cnt} !== {exp_field(0), exp_field(1), exp_field(2), exp_field(3), exp_rst()}) begin n_err++; $display("FAIL commit_others: got %h expected %h", {t0h, rst_cnt}, {exp_field(0), exp_rst()}); end
    idle_step(8'h04);
    n_vec++; if (upd !== 8'h00) begin n_err++; $display("FAIL commit_upd_single: got %h expected 00", upd); end
  endtask

  task automatic test_write_vs_xfer();
    step(1'b1, {4'd1, 3'd0}, 8'h77, 1'b0, 8'h00, 8'h00);
    step(1'b1, {4'd1, 3'd7}, 8'h01, 1'b0, 8'h00, 8'h00);
    step(1'b1, {4'd1, 3'd0}, 8'h55, 1'b0, 8'h00, 8'h02);
    n_vec++; if (t0h[15:8] !== 8'h77 || pend[1] !== 1'b0 || upd !== 8'h02) begin n_err++; $display("FAIL write_xfer_active: got %h/%b/%h expected 77/0/02", t0h[15:8], pend[1], upd); end
    step(1'b0, 7'h00, 8'h00, 1'b1, {1'b0, 4'd1, 3'd0}, 8'h00);
    n_vec++; if (rd_data !== 8'h55) begin n_err++; $display("FAIL write_xfer_shadow: got %h expected 55", rd_data); end
  endtask

  task automatic test_commit_vs_xfer();
    int pulses = 0;
    step(1'b1, {4'd3, 3'd1}, 8'h9A, 1'b0, 8'h00, 8'h00);
    step(1'b1, {4'd3, 3'd7}, 8'h01, 1'b0, 8'h00, 8'h00);
    step(1'b1, {4'd3, 3'd7}, 8'hFF, 1'b0, 8'h00, 8'h08);
    pulses += int'(upd[3]);
    n_vec++; if (pend[3] !== 1'b1 || t0l[31:24] !== 8'h9A) begin n_err++; $display("FAIL commit_xfer_repend: got %b/%h expected 1/9a", pend[3], t0l[31:24]); end
    idle_step(8'h00); pulses += int'(upd[3]);
    idle_step(8'h08); pulses += int'(upd[3]);
    idle_step(8'h08); pulses += int'(upd[3]);
    n_vec++; if (pulses != 2 || pend[3] !== 1'b0) begin n_err++; $display("FAIL commit_xfer_pulses: got %0d/%b expected 2/0", pulses, pend[3]); end
  endtask

  task automatic test_out_of_range();
    step(1'b1, {4'd9, 3'd0}, 8'hEE, 1'b0, 8'h00, 8'hFF);
    step(1'b1, {4'd9, 3'd7}, 8'h01, 1'b0, 8'h00, 8'hFF);
    step(1'b1, {4'd9, 3'd4}, 8'h12, 1'b0, 8'h00, 8'hFF);
    n_vec++; if ({t0h, rst_cnt, pend, upd} !== {exp_field(0), exp_rst(), m_pend, 8'h00}) begin n_err++; $display("FAIL oor_no_effect: got %h expected %h", {t0h, rst_cnt, pend, upd}, {exp_field(0), exp_rst(), m_pend, 8'h00}); end
    step(1'b0, 7'h00, 8'h00, 1'b1, {1'b1, 4'd9, 3'd0}, 8'h00);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin n_err++; $display("FAIL oor_read: got %b/%h expected 1/00", rd_valid, rd_data); end
  endtask

  task automatic test_random();
    logic we, re;
    logic [6:0] wa;
    logic [7:0] wd, ra, idle;
    for (int i = 0; i < 600; i++) begin
      we   = 1'($urandom_range(0, 3) != 0);
      wa   = 7'($urandom);
      if ($urandom_range(0, 4) == 0) wa[2:0] = 3'd7;
      wd   = 8'($urandom);
      re   = 1'($urandom_range(0, 1));
      ra   = 8'($urandom);
      idle = 8'($urandom) & 8'($urandom);
      step(we, wa, wd, re, ra, idle);
      n_vec++; if ({t0h, t0l, t1h, t1l} !== {exp_field(0), exp_field(1), exp_field(2), exp_field(3)}) begin n_err++; $display("FAIL rand_timing @%0d: got %h expected %h", i, {t0h, t0l, t1h, t1l}, {exp_field(0), exp_field(1), exp_field(2), exp_field(3)}); end
      n_vec++; if (rst_cnt !== exp_rst()) begin n_err++; $display("FAIL rand_rst @%0d: got %h expected %h", i, rst_cnt, exp_rst()); end
      n_vec++; if (pend !== m_pend || upd !== m_upd) begin n_err++; $display("FAIL rand_pend_upd @%0d: got %h/%h expected %h/%h", i, pend, upd, m_pend, m_upd); end
      n_vec++; if (rd_valid !== m_rd_valid) begin n_err++; $display("FAIL rand_rd_valid @%0d: got %b expected %b", i, rd_valid, m_rd_valid); end
      if (m_rd_valid) begin
        n_vec++; if (rd_data !== m_rd_data) begin n_err++; $display("FAIL rand_rd_data @%0d: got %h expected %h", i, rd_data, m_rd_data); end
      end
    end
  endtask

  task automatic test_reset_pending();
    int pulses = 0;
    step(1'b1, {4'd4, 3'd0}, 8'h66, 1'b0, 8'h00, 8'h00);
    step(1'b1, {4'd4, 3'd7}, 8'h01, 1'b0, 8'h00, 8'h00);
    n_vec++; if (pend[4] !== 1'b1) begin n_err++; $display("FAIL rstpend_setup: got %b expected 1", pend[4]); end
    ch_idle = 8'hFF;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (pend !== 8'h00 || t0h !== 64'h1010101010101010 || rst_cnt !== {8{16'h1F40}}) begin n_err++; $display("FAIL rstpend_async: got %h/%h/%h expected 00/defaults", pend, t0h, rst_cnt); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_step(8'hFF);
      pulses += (upd != 8'h00) ? 1 : 0;
    end
    n_vec++; if (pulses != 0 || pend !== 8'h00 || t0h[39:32] !== 8'h10) begin n_err++; $display("FAIL rstpend_release: got %0d/%h/%h expected 0/00/10", pulses, pend, t0h[39:32]); end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; ch_idle = '0;
    model_reset();
    #23 rst_n = 1'b1;
    test_reset();
    test_shadow_write();
    test_commit_wait();
    test_write_vs_xfer();
    test_commit_vs_xfer();
    test_out_of_range();
    test_random();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
